// File: rtl/round_controller.sv
// round_controller: memory-game round sequencer.
// Per round it loads an N-entry LED pattern from an external generator,
// shows it step by step, then scores the player's button presses against
// it. A game is ROUNDS rounds; the score accumulates across rounds.
// Optional build macro: ROUND_TIMEOUT_EN (an idle player ends the round
// after TIMEOUT_TICKS cycles with no press).
//
// Pattern handshake: pat_req is high for the whole LOAD state; every cycle
// with pat_ack high transfers pat_value as the next entry. pat_req drops
// the cycle after the N-th ack.
module round_controller #(
  parameter int ROUNDS        = 5,
  parameter int SHOW_TICKS    = 50,
  parameter int GAP_TICKS     = 25,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [7:0] button,
  output logic       pat_req,
  input  logic       pat_ack,
  input  logic [2:0] pat_value,
  output logic [7:0] led,
  output logic [7:0] score,
  output logic [3:0] round_cnt,
  output logic       busy,
  output logic       game_over,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    INPUT    = 3'd4,
    SCORE    = 3'd5,
    GAP      = 3'd6,
    DONE     = 3'd7
  } state_t;

  // One shared tick counter times SHOW_ON, SHOW_OFF, GAP and the idle timeout.
  localparam int SG_MAX   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TICK_MAX = (SG_MAX > TIMEOUT_TICKS) ? SG_MAX : TIMEOUT_TICKS;
  localparam int TW       = $clog2(TICK_MAX + 1);

  state_t        state_q, state_n;
  logic [TW-1:0] tick_q;
  logic [2:0]    level_q;
  logic [2:0]    pat_buf [8];
  logic [2:0]    idx_q;    // next LOAD slot
  logic [2:0]    step_q;   // pattern step being shown
  logic [2:0]    k_q;      // next pattern entry the player must match
  logic [3:0]    hits_q;
  logic [7:0]    score_q;
  logic [3:0]    round_cnt_q;

  logic       level_ok;
  logic       start_ok;
  logic [2:0] last_idx;
  logic       last_load;
  logic       show_done;
  logic       gap_done;
  logic       press;
  logic       hit;
  logic       last_entry;
  logic       timeout;
  logic [8:0] score_sum;
  logic [7:0] led_c;

  assign level_ok  = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);
  assign start_ok  = start && level_ok && ((state_q == IDLE) || (state_q == DONE));

  // Last valid index N-1 for the latched difficulty (N = 3, 5, 8).
  always_comb begin
    last_idx = 3'd2;
    case (level_q)
      3'b010:  last_idx = 3'd4;
      3'b100:  last_idx = 3'd7;
      default: last_idx = 3'd2;
    endcase
  end

  assign last_load  = pat_ack && (idx_q == last_idx);
  assign show_done  = (tick_q == TW'(SHOW_TICKS - 1));
  assign gap_done   = (tick_q == TW'(GAP_TICKS - 1));
  assign press      = |button;
  assign hit        = (button == (8'd1 << pat_buf[k_q]));
  assign last_entry = press && (k_q == last_idx);
  assign score_sum  = {1'b0, score_q} + {5'b0, hits_q};

`ifdef ROUND_TIMEOUT_EN
  assign timeout = !press && (tick_q == TW'(TIMEOUT_TICKS - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  // Next-state decode and LED drive.
  always_comb begin
    state_n = state_q;
    led_c   = 8'h00;
    case (state_q)
      IDLE: begin
        if (start_ok) state_n = LOAD;
      end
      LOAD: begin
        if (last_load) state_n = SHOW_ON;
      end
      SHOW_ON: begin
        led_c = 8'd1 << pat_buf[step_q];
        if (show_done) state_n = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (gap_done) state_n = (step_q == last_idx) ? INPUT : SHOW_ON;
      end
      INPUT: begin
        led_c = button;
        if (last_entry || timeout) state_n = SCORE;
      end
      SCORE: begin
        state_n = GAP;
      end
      GAP: begin
        if (gap_done) state_n = (round_cnt_q == 4'(ROUNDS)) ? DONE : LOAD;
      end
      DONE: begin
        led_c = 8'hFF;
        if (start_ok) state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Tick counter: restarts on every state change; in INPUT it counts idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= '0;
    end else if (state_n != state_q) begin
      tick_q <= '0;
    end else begin
      case (state_q)
        SHOW_ON, SHOW_OFF, GAP: tick_q <= tick_q + 1'b1;
`ifdef ROUND_TIMEOUT_EN
        INPUT: tick_q <= press ? '0 : tick_q + 1'b1;
`endif
        default: tick_q <= tick_q;
      endcase
    end
  end

  // Game datapath: level latch, pattern buffer, step/entry indices, hits, score.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q     <= 3'b001;
      idx_q       <= '0;
      step_q      <= '0;
      k_q         <= '0;
      hits_q      <= '0;
      score_q     <= '0;
      round_cnt_q <= '0;
      for (int i = 0; i < 8; i++) pat_buf[i] <= '0;
    end else begin
      if (start_ok) begin
        level_q     <= level;
        score_q     <= '0;
        round_cnt_q <= '0;
      end
      if (state_q == LOAD && pat_ack) begin
        pat_buf[idx_q] <= pat_value;
        idx_q          <= last_load ? 3'd0 : idx_q + 3'd1;
        if (last_load) begin
          step_q <= '0;
          k_q    <= '0;
          hits_q <= '0;
        end
      end
      if (state_q == SHOW_OFF && gap_done && step_q != last_idx) begin
        step_q <= step_q + 3'd1;
      end
      if (state_q == INPUT && press) begin
        k_q    <= last_entry ? 3'd0 : k_q + 3'd1;
        hits_q <= hits_q + {3'b0, hit};
      end
      if (state_q == SCORE) begin
        score_q     <= score_sum[8] ? 8'hFF : score_sum[7:0];
        round_cnt_q <= round_cnt_q + 4'd1;
        k_q         <= '0;
        hits_q      <= '0;
        step_q      <= '0;
      end
    end
  end

  assign pat_req   = (state_q == LOAD);
  assign led       = led_c;
  assign score     = score_q;
  assign round_cnt = round_cnt_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign game_over = (state_q == DONE);
  assign dbg_state = state_q;

endmodule
